mac_pe: RTL
===========

MAC_PE -- requirements
Module: mac_pe

Interface
REQ-001 Parameter DATA_W, default 8, sets the activation and weight width (signed two's complement).
REQ-002 Parameter ACC_W, default 32, sets the partial-sum width; legal only if ACC_W >= 2*DATA_W+1.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 w_in  in  DATA_W  weight arriving on the north weight chain.
REQ-006 w_valid  in  1  qualifies w_in.
REQ-007 w_ready  out  1  shadow weight register is empty and will capture w_in.
REQ-008 w_out  out  DATA_W  weight forwarded south on the chain.
REQ-009 w_out_valid  out  1  qualifies w_out.
REQ-010 w_swap  in  1  commits the shadow weight to the active weight.
REQ-011 a_in  in  DATA_W  activation from west.
REQ-012 a_valid_in  in  1  qualifies a_in.
REQ-013 a_out  out  DATA_W  activation forwarded east.
REQ-014 a_valid_out  out  1  qualifies a_out.
REQ-015 psum_in  in  ACC_W  partial sum from north.
REQ-016 psum_valid_in  in  1  qualifies psum_in.
REQ-017 psum_out  out  ACC_W  partial sum to south.
REQ-018 psum_valid_out  out  1  qualifies psum_out.
REQ-019 sat_flag  out  1  saturation occurred on the current psum_out.

Function
REQ-020 Weight FSM has 2 states: EMPTY (w_ready=1) and FULL (w_ready=0).
REQ-021 In EMPTY, w_valid=1: w_in goes to shadow and the FSM moves to FULL next cycle; w_out_valid stays 0.
REQ-022 In FULL, w_valid=1, w_swap=0: w_in is registered to w_out with w_out_valid=1, 1-cycle latency; shadow is unchanged.
REQ-023 In FULL, w_swap=1: active weight takes the shadow value next cycle.
- Without w_valid in the same cycle: the FSM moves to EMPTY.
- With w_valid in the same cycle: w_in enters shadow, the FSM stays FULL, and nothing is forwarded.
REQ-024 In EMPTY, w_swap is ignored; the active weight is unchanged.
REQ-025 w_out_valid is 0 in every cycle not covered by REQ-022.
REQ-026 Activation path: a_out and a_valid_out are a_in and a_valid_in delayed 1 cycle, unconditionally.
REQ-027 MAC output rules (1-cycle latency, registered):
- psum_valid_out <= a_valid_in | psum_valid_in.
- psum_out <= P + S, where P = sext(a_in)*sext(w_active) if a_valid_in, else 0.
- S = psum_in if psum_valid_in, else 0.
REQ-028 The product is 2*DATA_W bits signed, sign-extended to ACC_W before the add.
REQ-029 A w_swap in cycle N affects MAC results from inputs sampled in cycle N+1 onward; cycle N uses the old weight.
REQ-030 When psum_valid_out=0, psum_out holds its previous value and sat_flag=0.

Reset
REQ-031 While reset=1, state is forced at the next edge:
- active weight, shadow weight, w_out, a_out and psum_out are 0;
- all *_valid outputs and sat_flag are 0;
- w_ready is 1 (EMPTY).
REQ-032 Reset overrides all inputs in the same cycle; a load or swap in progress is discarded.

Configuration
REQ-033 Macro MAC_PE_SATURATE_EN selects the add behaviour.
- Defined: the ACC_W signed sum clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1) on overflow, and sat_flag=1 with that psum_valid_out.
- Undefined: the sum wraps modulo 2^ACC_W and sat_flag is constant 0.

Verification
REQ-034 Reset, then w_valid with w_in=0x05, then w_swap, then a_in=0x03 with psum_in=10 (both valid) -> psum_out=25 and psum_valid_out=1 one cycle later; w_ready reads 1, 0, 1.
REQ-035 Shadow FULL, then w_valid with w_in=0x7F -> next cycle w_out=0x7F and w_out_valid=1; shadow unchanged.
REQ-036 Active weight 0x80 (-128), a_in=0x80 with psum_valid_in=0 -> psum_out=16384.
REQ-037 Active weight 0x02, w_swap to 0x04 while a_in=1 in the same cycle and again the next cycle -> psum_out=2 then 4.
REQ-038 psum_in=0x7FFFFFFF, a_in=1, weight=1:
- with MAC_PE_SATURATE_EN defined -> psum_out=0x7FFFFFFF, sat_flag=1;
- without it -> psum_out=0x80000000, sat_flag=0.
REQ-039 reset asserted while FULL with valid data in flight -> next cycle all outputs 0 and w_ready=1.

Source files
------------

// File: rtl/mac_pe_if.sv
// Port bundle for one mac_pe tile: weight chain, activation and partial-sum links.
// The PE connects through the slave modport; whatever drives its inputs uses master.
interface mac_pe_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
);
  logic signed [DATA_W-1:0] w_in;
  logic                     w_valid;
  logic                     w_ready;
  logic signed [DATA_W-1:0] w_out;
  logic                     w_out_valid;
  logic                     w_swap;
  logic signed [DATA_W-1:0] a_in;
  logic                     a_valid_in;
  logic signed [DATA_W-1:0] a_out;
  logic                     a_valid_out;
  logic signed [ACC_W-1:0]  psum_in;
  logic                     psum_valid_in;
  logic signed [ACC_W-1:0]  psum_out;
  logic                     psum_valid_out;
  logic                     sat_flag;

  modport master (
    output w_in, w_valid, w_swap, a_in, a_valid_in, psum_in, psum_valid_in,
    input  w_ready, w_out, w_out_valid, a_out, a_valid_out, psum_out, psum_valid_out, sat_flag
  );

  modport slave (
    input  w_in, w_valid, w_swap, a_in, a_valid_in, psum_in, psum_valid_in,
    output w_ready, w_out, w_out_valid, a_out, a_valid_out, psum_out, psum_valid_out, sat_flag
  );
endinterface

// File: rtl/mac_pe.sv
// Systolic-array MAC processing element with double-buffered (shadow/active) weight.
// Define MAC_PE_SATURATE_EN to clamp the accumulate on overflow instead of wrapping.
module mac_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input logic     clock,
  input logic     reset,
  mac_pe_if.slave bus
);
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} w_state_t;

  w_state_t                 state_q, state_d;
  logic                     shadow_ld, swap_en, fwd_en;
  logic signed [DATA_W-1:0] w_shadow, w_active;
  logic signed [DATA_W-1:0] w_out_p1, a_p1;
  logic                     w_vld_p1, a_vld_p1, vld_p1;
  logic signed [ACC_W-1:0]  psum_p1;

  logic signed [PROD_W-1:0] a_ext_p0, w_ext_p0, prod_p0;
  logic signed [ACC_W-1:0]  p_ext_p0, s_p0, sum_p0;
  logic                     vld_p0;

  always_comb begin
    state_d   = state_q;
    shadow_ld = 1'b0;
    swap_en   = 1'b0;
    fwd_en    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (bus.w_valid) begin
          shadow_ld = 1'b1;
          state_d   = FULL;
        end
      end
      FULL: begin
        // A swap frees the shadow; a same-cycle load refills it instead of forwarding.
        if (bus.w_swap) begin
          swap_en = 1'b1;
          if (bus.w_valid) shadow_ld = 1'b1;
          else             state_d   = EMPTY;
        end else if (bus.w_valid) begin
          fwd_en = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= EMPTY;
      w_shadow <= '0;
      w_active <= '0;
      w_out_p1 <= '0;
      w_vld_p1 <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_vld_p1 <= fwd_en;
      if (swap_en)   w_active <= w_shadow;
      if (shadow_ld) w_shadow <= bus.w_in;
      if (fwd_en)    w_out_p1 <= bus.w_in;
    end
  end

  // ---- p0: multiply and operand select (combinational from inputs) ----
  assign a_ext_p0 = {{DATA_W{bus.a_in[DATA_W-1]}}, bus.a_in};
  assign w_ext_p0 = {{DATA_W{w_active[DATA_W-1]}}, w_active};
  assign prod_p0  = a_ext_p0 * w_ext_p0;
  assign p_ext_p0 = bus.a_valid_in ? {{(ACC_W-PROD_W){prod_p0[PROD_W-1]}}, prod_p0} : '0;
  assign s_p0     = bus.psum_valid_in ? bus.psum_in : '0;
  assign vld_p0   = bus.a_valid_in | bus.psum_valid_in;

`ifdef MAC_PE_SATURATE_EN
  logic ovf_p0, sat_p1;

  function automatic logic signed [ACC_W-1:0] add_sat(
    input  logic signed [ACC_W-1:0] x,
    input  logic signed [ACC_W-1:0] y,
    output logic                    ovf
  );
    logic signed [ACC_W:0] wide;
    wide = {x[ACC_W-1], x} + {y[ACC_W-1], y};
    ovf  = wide[ACC_W] ^ wide[ACC_W-1];
    if (!ovf)            add_sat = wide[ACC_W-1:0];
    else if (wide[ACC_W]) add_sat = {1'b1, {(ACC_W-1){1'b0}}};
    else                 add_sat = {1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  always_comb begin
    ovf_p0 = 1'b0;
    sum_p0 = add_sat(p_ext_p0, s_p0, ovf_p0);
  end

  always_ff @(posedge clock) begin
    if (reset) sat_p1 <= 1'b0;
    else       sat_p1 <= vld_p0 & ovf_p0;
  end

  assign bus.sat_flag = sat_p1;
`else
  function automatic logic signed [ACC_W-1:0] add_wrap(
    input logic signed [ACC_W-1:0] x,
    input logic signed [ACC_W-1:0] y
  );
    add_wrap = x + y;
  endfunction

  assign sum_p0       = add_wrap(p_ext_p0, s_p0);
  assign bus.sat_flag = 1'b0;
`endif

  // ---- p1: registered outputs; psum holds when nothing valid arrives ----
  always_ff @(posedge clock) begin
    if (reset) begin
      a_p1     <= '0;
      a_vld_p1 <= 1'b0;
      psum_p1  <= '0;
      vld_p1   <= 1'b0;
    end else begin
      a_p1     <= bus.a_in;
      a_vld_p1 <= bus.a_valid_in;
      vld_p1   <= vld_p0;
      if (vld_p0) psum_p1 <= sum_p0;
    end
  end

  assign bus.w_ready        = (state_q == EMPTY);
  assign bus.w_out          = w_out_p1;
  assign bus.w_out_valid    = w_vld_p1;
  assign bus.a_out          = a_p1;
  assign bus.a_valid_out    = a_vld_p1;
  assign bus.psum_out       = psum_p1;
  assign bus.psum_valid_out = vld_p1;
endmodule
